// File: rtl/neuron_pkg.sv
// Shared types for the leaky integrate-and-fire neuron: FSM states and
// the per-channel signed weight vector.
package neuron_pkg;

  localparam int unsigned WEIGHT_W = 4;
  localparam int unsigned MAX_IN   = 16;

  typedef enum logic [1:0] {
    StIntegrate,
    StFire,
    StRelease,
    StRefrac
  } neuron_state_t;

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef weight_t [MAX_IN-1:0] weight_vec_t;

  // Channels 0..3 weigh 4, 3, -2, 1; unused channels weigh 0.
  localparam weight_vec_t DEFAULT_WEIGHTS = 64'h0000_0000_0000_1e34;

endpackage

// File: rtl/lif_neuron_if.sv
// Spike-side bundle of the neuron: N_IN input req/ack channels, one output
// req/ack channel and the observable membrane potential.
interface lif_neuron_if #(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned DATA_BITS = 8
);
  logic [N_IN-1:0]      in_data;
  logic [N_IN-1:0]      in_req;
  logic [N_IN-1:0]      in_ack;
  logic                 out_data;
  logic                 out_req;
  logic                 out_ack;
  logic [DATA_BITS-1:0] potential;

  modport master (
    output in_data, in_req, out_ack,
    input  in_ack, out_data, out_req, potential
  );

  modport slave (
    input  in_data, in_req, out_ack,
    output in_ack, out_data, out_req, potential
  );
endinterface

// File: rtl/spike_rx.sv
// One 4-phase spike receiver: acknowledges a request and emits a one-cycle
// event pulse when the accepted spike bit is set.
module spike_rx (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic data_i,
  output logic ack_o,
  output logic event_o
);
  logic ack_q, ack_d;
  logic accept;

  assign accept = req_i & ~ack_q;

  always_comb begin
    ack_d = ack_q;
    if (accept) begin
      ack_d = 1'b1;
    end else if (!req_i) begin
      ack_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ack_o   = ack_q;
  assign event_o = accept & data_i;
endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted multi-channel integration with a
// saturating potential, periodic leak, handshaked output spike and refractory.
module lif_neuron
  import neuron_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned WEIGHT_BITS = WEIGHT_W,
  parameter weight_vec_t WEIGHTS     = DEFAULT_WEIGHTS,
  parameter int unsigned THOLD       = 8,
  parameter int unsigned LEAK        = 1,
  parameter int unsigned LEAK_PERIOD = 16,
  parameter int unsigned REFRAC      = 2
) (
  input logic         clk,
  input logic         rst_n,
  lif_neuron_if.slave bus
);
  localparam int unsigned SumW    = DATA_BITS + WEIGHT_BITS + $clog2(N_IN) + 1;
  localparam int unsigned LeakW   = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int unsigned RefracW = (REFRAC > 1) ? $clog2(REFRAC) : 1;

  localparam logic [DATA_BITS-1:0] PotMax     = '1;
  localparam logic [DATA_BITS-1:0] Thold      = DATA_BITS'(THOLD);
  localparam logic [LeakW-1:0]     LeakLast   = LeakW'(LEAK_PERIOD - 1);
  // Meaningless when REFRAC is 0, since the refractory state is then skipped.
  localparam logic [RefracW-1:0]   RefracLast = RefracW'(REFRAC - 1);

  neuron_state_t          state_q, state_d;
  logic [DATA_BITS-1:0]   pot_q, pot_d, next_pot;
  logic [LeakW-1:0]       leak_cnt_q, leak_cnt_d;
  logic [RefracW-1:0]     refrac_cnt_q, refrac_cnt_d;
  logic                   out_req_q, out_req_d;
  logic                   leak_tick;
  logic signed [SumW-1:0] sum;
  weight_t                w;
  logic [N_IN-1:0]        evt;
  logic [N_IN-1:0]        in_ack;

  for (genvar i = 0; i < N_IN; i++) begin : g_rx
    spike_rx u_rx (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .req_i  (bus.in_req[i]),
      .data_i (bus.in_data[i]),
      .ack_o  (in_ack[i]),
      .event_o(evt[i])
    );
  end

  assign leak_tick = (state_q == StIntegrate) && (leak_cnt_q == LeakLast);

  // Wide signed sum so that any combination of events plus leak cannot wrap.
  always_comb begin
    w   = '0;
    sum = SumW'(pot_q);
    for (int unsigned i = 0; i < N_IN; i++) begin
      w = WEIGHTS[i];
      if (evt[i]) begin
        sum = sum + {{(SumW - WEIGHT_W){w[WEIGHT_W-1]}}, w};
      end
    end
    if (leak_tick) begin
      sum = sum - SumW'(LEAK);
    end
    if (sum[SumW-1]) begin
      next_pot = '0;
    end else if (sum > $signed(SumW'(PotMax))) begin
      next_pot = PotMax;
    end else begin
      next_pot = sum[DATA_BITS-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    pot_d        = pot_q;
    leak_cnt_d   = '0;
    refrac_cnt_d = '0;
    case (state_q)
      StIntegrate: begin
        if (next_pot >= Thold) begin
          pot_d   = '0;
          state_d = StFire;
        end else begin
          pot_d      = next_pot;
          leak_cnt_d = leak_tick ? '0 : leak_cnt_q + 1'b1;
        end
      end
      StFire: begin
        if (bus.out_ack) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!bus.out_ack) begin
          state_d = (REFRAC == 0) ? StIntegrate : StRefrac;
        end
      end
      StRefrac: begin
        if (refrac_cnt_q == RefracLast) begin
          state_d = StIntegrate;
        end else begin
          refrac_cnt_d = refrac_cnt_q + 1'b1;
        end
      end
      default: state_d = StIntegrate;
    endcase
    out_req_d = (state_d == StFire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIntegrate;
      pot_q        <= '0;
      leak_cnt_q   <= '0;
      refrac_cnt_q <= '0;
      out_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pot_q        <= pot_d;
      leak_cnt_q   <= leak_cnt_d;
      refrac_cnt_q <= refrac_cnt_d;
      out_req_q    <= out_req_d;
    end
  end

  assign bus.in_ack    = in_ack;
  assign bus.out_req   = out_req_q;
  assign bus.out_data  = out_req_q;
  assign bus.potential = pot_q;
endmodule
